// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side (datapath / bench) drives the stage addresses and controls,
// and the slave side (hazard unit) returns stalls, flushes, forwarding and status.
interface pipe_hazard_ctrl_if;
   logic [4:0]  ad1d, ad2d;           // decode-stage sources
   logic [4:0]  ad1e, ad2e, rde;      // execute-stage sources and destination
   logic        ldE;                  // execute-stage instruction is a load
   logic        pcSrce;               // taken branch/jump resolved in execute
   logic        regWrtm, regWrtw;     // memory / writeback write enables
   logic [4:0]  rdm, rdw;             // memory / writeback destinations
   logic        dmemReqm, dmemRdym;   // data-memory request and ready
   logic        stallf, stalld, stalle, stallm;
   logic        flushd, flushe, flushw;
   logic [1:0]  fwdAe, fwdBe;
   logic [1:0]  state;
   logic        memErr;
   logic [15:0] stallCnt;

   modport master (
      output ad1d, ad2d, ad1e, ad2e, rde, ldE, pcSrce,
             regWrtm, regWrtw, rdm, rdw, dmemReqm, dmemRdym,
      input  stallf, stalld, stalle, stallm, flushd, flushe, flushw,
             fwdAe, fwdBe, state, memErr, stallCnt
   );

   modport slave (
      input  ad1d, ad2d, ad1e, ad2e, rde, ldE, pcSrce,
             regWrtm, regWrtw, rdm, rdw, dmemReqm, dmemRdym,
      output stallf, stalld, stalle, stallm, flushd, flushe, flushw,
             fwdAe, fwdBe, state, memErr, stallCnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch redirect
// flush, load-use bubble, operand forwarding select and a saturating count of
// fetch-stall cycles.
module pipe_hazard_ctrl (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MEMWAIT = 2'b01,
      ERR     = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        mem_busy;
   logic        load_use;

   assign mem_busy = hz.dmemReqm & ~hz.dmemRdym;
   // x0 is never a real producer, so it can never cause a bubble.
   assign load_use = hz.ldE && (hz.rde != 5'd0) &&
                     ((hz.rde == hz.ad1d) || (hz.rde == hz.ad2d));

   // Memory stage wins over writeback because it holds the younger result.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (hz.regWrtm && (hz.rdm != 5'd0) && (hz.rdm == src))
         return 2'b10;
      else if (hz.regWrtw && (hz.rdw != 5'd0) && (hz.rdw == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // State, wait counter and stall counter registers.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_q      <= 8'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next-state logic and same-cycle stall/flush decode.
   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      hz.stallf = 1'b0;
      hz.stalld = 1'b0;
      hz.stalle = 1'b0;
      hz.stallm = 1'b0;
      hz.flushd = 1'b0;
      hz.flushe = 1'b0;
      hz.flushw = 1'b0;

      case (state_q)
         RUN: begin
            wait_d = 8'd0;
            if (mem_busy) state_d = MEMWAIT;
         end
         MEMWAIT: begin
            // ERR is entered after 256 consecutive busy cycles: one in RUN
            // plus 255 counted here.
            wait_d = wait_q + 8'd1;
            if (!mem_busy)              state_d = RUN;
            else if (wait_d == 8'd255)  state_d = ERR;
         end
         ERR: ;  // sticky until reset
         default: state_d = RUN;
      endcase

      if (rst) begin
         // all controls quiet while reset is held
      end else if (state_q == ERR || mem_busy) begin
         hz.stallf = 1'b1;
         hz.stalld = 1'b1;
         hz.stalle = 1'b1;
         hz.stallm = 1'b1;
         hz.flushw = 1'b1;
      end else if (hz.pcSrce) begin
         hz.flushd = 1'b1;
         hz.flushe = 1'b1;
      end else if (load_use) begin
         hz.stallf = 1'b1;
         hz.stalld = 1'b1;
         hz.flushe = 1'b1;
      end
   end

   // Saturating count of cycles in which fetch is held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hz.stallf && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Forwarding is purely combinational and ignores FSM state and stalls.
   always_comb begin
      hz.fwdAe = fwd_sel(hz.ad1e);
      hz.fwdBe = fwd_sel(hz.ad2e);
   end

   assign hz.state    = state_q;
   assign hz.memErr   = (state_q == ERR);
   assign hz.stallCnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: ad1d, ad2d  in  5 each  decode-stage source register addresses.
REQ-004 SHALL have ports: ad1e, ad2e, rde  in  5 each  execute-stage source and destination addresses.
REQ-005 SHALL have port: ldE  in  1  execute-stage instruction is a load (result from memory).
REQ-006 SHALL have port: pcSrce  in  1  taken branch or jump resolved in execute.
REQ-007 SHALL have ports: regWrtm, rdm / regWrtw, rdw  in  1,5 / 1,5  memory- and writeback-stage write enable and destination.
REQ-008 SHALL have ports: dmemReqm, dmemRdym  in  1 each  data-memory request in memory stage and its ready.
REQ-009 SHALL have ports: stallf, stalld, stalle, stallm  out  1 each  hold fetch PC and the F/D, D/E, E/M registers.
REQ-010 SHALL have ports: flushd, flushe, flushw  out  1 each  synchronous clear of the F/D, D/E, M/W registers.
REQ-011 SHALL have ports: fwdAe, fwdBe  out  2 each  operand forward select (00 register file, 01 writeback, 10 memory).
REQ-012 SHALL have ports: state  out 2;  memErr  out 1;  stallCnt  out 16.

Function
REQ-013 SHALL implement FSM RUN=00, MEMWAIT=01, ERR=10; state drives the state output.
REQ-014 SHALL define memBusy = dmemReqm AND NOT dmemRdym.
REQ-015 SHALL transition RUN->MEMWAIT on memBusy; MEMWAIT->RUN in the cycle after dmemRdym=1; MEMWAIT->ERR when the wait counter reaches 255 with memBusy still 1.
REQ-016 SHALL use an 8-bit wait counter: cleared in RUN, incremented each MEMWAIT cycle.
REQ-017 SHALL, in ERR, hold all stall outputs at 1 and flushw at 1 until rst; memErr = 1 iff state = ERR.
REQ-018 SHALL, whenever memBusy=1 (any state), assert stallf, stalld, stalle, stallm and flushw, and assert no other flush (freeze, highest priority).
REQ-019 SHALL, when memBusy=0 and pcSrce=1, assert flushd and flushe with no stalls (redirect, second priority).
REQ-020 SHALL, when memBusy=0, pcSrce=0, ldE=1, rde!=0 and (rde=ad1d or rde=ad2d), assert stallf, stalld and flushe for that cycle (load-use bubble).
REQ-021 SHALL otherwise drive all stall and flush outputs to 0.
REQ-022 SHALL drive stall and flush outputs combinationally from inputs and state (same-cycle).
REQ-023 SHALL set fwdAe=10 if regWrtm, rdm!=0 and rdm=ad1e; else 01 if regWrtw, rdw!=0 and rdw=ad1e; else 00; fwdBe likewise on ad2e; memory stage wins when both match.
REQ-024 SHALL compute forwarding independently of FSM state and stalls.
REQ-025 SHALL increment stallCnt in each cycle stallf=1, saturating at 0xFFFF.
REQ-026 SHALL never forward or bubble on register x0.

Reset
REQ-027 SHALL on rst=1 force state=RUN, wait counter=0, stallCnt=0, memErr=0 immediately (asynchronous).
REQ-028 SHALL, during reset, output all stall and flush signals as 0; forwarding remains combinational.
REQ-029 SHALL abandon any in-progress MEMWAIT or ERR on reset mid-operation, with no residual stall after release.

Verification
REQ-030 Load-use: ldE=1, rde=5, ad1d=5 -> stallf=stalld=flushe=1 one cycle, stallCnt +1.
REQ-031 Redirect with load-use: pcSrce=1, ldE=1, rde=ad2d=7 -> flushd=flushe=1, stallf=0.
REQ-032 Memory wait: dmemReqm=1, dmemRdym=0 for 3 cycles then 1 -> state 01 for 3 cycles, stalls+flushw for 3 cycles, RUN next cycle, stallCnt=3.
REQ-033 Timeout: dmemRdym held 0 for 256 cycles -> state=10, memErr=1 persisting; rst -> state=00, memErr=0, stallCnt=0.
REQ-034 Forwarding: regWrtm=1, rdm=3, regWrtw=1, rdw=3, ad1e=3, ad2e=0 -> fwdAe=10, fwdBe=00; regWrtm=0 -> fwdAe=01.
REQ-035 Saturation: 70000 load-use cycles -> stallCnt=0xFFFF.
